wb_regfile: RTL

- Writeback-side consumer of the MEM/WB pipeline register.
- Selects writeback data (memory load vs ALU result) and commits it to a 32-entry architectural register file.
- Serves the two ID-stage read ports with same-cycle write-through bypass.
- Holds a one-cycle "last retired write" record for the EX forwarding unit.

---
 rtl/wb_regfile.sv | 81 ++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback stage: selects load vs ALU data, commits it to the register file,
// serves two write-through read ports and keeps a one-cycle retire record.
module wb_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              RegWrite_i,
  input  logic              Mem2Reg_i,
  input  logic [DATA_W-1:0] ReadData_i,
  input  logic [DATA_W-1:0] ALU_data_i,
  input  logic [ADDR_W-1:0] RDaddr_i,
  input  logic [ADDR_W-1:0] RS1addr_i,
  input  logic [ADDR_W-1:0] RS2addr_i,
  output logic [DATA_W-1:0] RS1data_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [DATA_W-1:0] WBdata_o,
  output logic              WBvalid_o,
  output logic [ADDR_W-1:0] WBaddr_o,
  output logic [DATA_W-1:0] WBlast_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              we;
  logic              rd_is_zero;

  assign WBdata_o   = Mem2Reg_i ? ReadData_i : ALU_data_i;
  assign rd_is_zero = (RDaddr_i == '0);
  assign we         = RegWrite_i && !(ZERO_REG && rd_is_zero);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[RDaddr_i] <= WBdata_o;
    end
  end

  // Record is updated every edge; WBaddr_o/WBlast_o are meaningful only with WBvalid_o.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      WBvalid_o <= 1'b0;
      WBaddr_o  <= '0;
      WBlast_o  <= '0;
    end else begin
      WBvalid_o <= we;
      WBaddr_o  <= RDaddr_i;
      WBlast_o  <= WBdata_o;
    end
  end

  // Reads are forced to zero while reset is held, so a pending bypass cannot leak out.
  always_comb begin
    RS1data_o = regs[RS1addr_i];
    if (!rst_i) begin
      RS1data_o = '0;
    end else if (ZERO_REG && (RS1addr_i == '0)) begin
      RS1data_o = '0;
    end else if (we && (RDaddr_i == RS1addr_i)) begin
      RS1data_o = WBdata_o;
    end
  end

  always_comb begin
    RS2data_o = regs[RS2addr_i];
    if (!rst_i) begin
      RS2data_o = '0;
    end else if (ZERO_REG && (RS2addr_i == '0)) begin
      RS2data_o = '0;
    end else if (we && (RDaddr_i == RS2addr_i)) begin
      RS2data_o = WBdata_o;
    end
  end

endmodule
